// File: rtl/alu_pkg.sv
// Shared definitions for the nibble-serial ALU: opcodes, flag positions, FSM states
// and small opcode-classification helpers.
package alu_pkg;

    localparam logic [3:0] OP_ADD  = 4'h0;
    localparam logic [3:0] OP_ADC  = 4'h1;
    localparam logic [3:0] OP_SUB  = 4'h2;
    localparam logic [3:0] OP_SBC  = 4'h3;
    localparam logic [3:0] OP_CP   = 4'h4;
    localparam logic [3:0] OP_AND  = 4'h5;
    localparam logic [3:0] OP_OR   = 4'h6;
    localparam logic [3:0] OP_XOR  = 4'h7;
    localparam logic [3:0] OP_RL   = 4'h8;
    localparam logic [3:0] OP_RR   = 4'h9;
    localparam logic [3:0] OP_SLA  = 4'hA;
    localparam logic [3:0] OP_SRL  = 4'hB;
    localparam logic [3:0] OP_SWAP = 4'hC;
    localparam logic [3:0] OP_RLC  = 4'hD;
    localparam logic [3:0] OP_RRC  = 4'hE;
    localparam logic [3:0] OP_SRA  = 4'hF;

    localparam int FLAG_Z = 7;
    localparam int FLAG_N = 6;
    localparam int FLAG_H = 5;
    localparam int FLAG_C = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    function automatic logic is_arith(input logic [3:0] op);
        return op <= OP_CP;
    endfunction

    function automatic logic is_sub(input logic [3:0] op);
        return (op == OP_SUB) || (op == OP_SBC) || (op == OP_CP);
    endfunction

    // Right-going shifts must start at the top nibble so the shifted-in bit flows downwards.
    function automatic logic msb_first(input logic [3:0] op);
        return (op == OP_RR) || (op == OP_SRL) || (op == OP_RRC) || (op == OP_SRA);
    endfunction

    function automatic logic chain_seed(input logic [3:0] op, input logic carry,
                                        input logic a_msb, input logic a_lsb);
        case (op)
            OP_ADC, OP_SBC, OP_RL, OP_RR: return carry;
            OP_RLC, OP_SRA:               return a_msb;
            OP_RRC:                       return a_lsb;
            default:                      return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/alu_nibble_serial_if.sv
// Request/response bundle between the register file side (master) and the
// nibble-serial ALU (slave).
interface alu_nibble_serial_if #(
    parameter int WIDTH = 8
);
    logic             start_i;
    logic [3:0]       op_i;
    logic [WIDTH-1:0] a_i;
    logic [WIDTH-1:0] b_i;
    logic             carry_i;
    logic             busy_o;
    logic             done_o;
    logic [WIDTH-1:0] res_o;
    logic [7:0]       flags_o;

    modport master (
        output start_i, op_i, a_i, b_i, carry_i,
        input  busy_o, done_o, res_o, flags_o
    );

    modport slave (
        input  start_i, op_i, a_i, b_i, carry_i,
        output busy_o, done_o, res_o, flags_o
    );
endinterface

// File: rtl/alu4_slice.sv
// Combinational 4-bit ALU slice: one nibble of result plus the bit chained to the
// next nibble (carry/borrow for arithmetic, shifted-out bit for shifts).
module alu4_slice
    import alu_pkg::*;
(
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic [3:0] op,
    input  logic       chain_in,
    input  logic       shift_in,
    output logic [3:0] res,
    output logic       chain_out
);
    logic [4:0] sum;
    logic [4:0] diff;

    assign sum  = {1'b0, a} + {1'b0, b} + {4'b0000, chain_in};
    assign diff = {1'b0, a} - {1'b0, b} - {4'b0000, chain_in};

    always_comb begin
        res       = 4'h0;
        chain_out = 1'b0;
        case (op)
            OP_ADD, OP_ADC:         {chain_out, res} = sum;
            OP_SUB, OP_SBC, OP_CP:  {chain_out, res} = diff;
            OP_AND:                 res = a & b;
            OP_OR:                  res = a | b;
            OP_XOR:                 res = a ^ b;
            OP_RL, OP_SLA, OP_RLC: begin
                res       = {a[2:0], shift_in};
                chain_out = a[3];
            end
            OP_RR, OP_SRL, OP_RRC, OP_SRA: begin
                res       = {shift_in, a[3:1]};
                chain_out = a[0];
            end
            OP_SWAP:                res = a;
            default: ;
        endcase
    end
endmodule

// File: rtl/alu_nibble_serial.sv
// Sequential ALU processing one nibble per clock; holds the FSM, nibble counter,
// operand/result registers and flag accumulation around a single alu4_slice.
module alu_nibble_serial
    import alu_pkg::*;
#(
    parameter int WIDTH     = 8,
    parameter int HC_NIBBLE = 0
) (
    input  logic                clk,
    input  logic                rst_n,
    alu_nibble_serial_if.slave  bus
);
    localparam int NIB = WIDTH / 4;
    localparam int CW  = (NIB > 1) ? $clog2(NIB) : 1;
    localparam logic [CW-1:0] LAST = CW'(NIB - 1);

    state_t           state;
    logic [3:0]       op_q;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic [WIDTH-1:0] res_q;
    logic [7:0]       flags_q;
    logic             busy_q;
    logic             done_q;
    logic [CW-1:0]    cnt;
    logic             link;
    logic             z_acc;
    logic             h_acc;

    logic [CW-1:0]    idx;
    logic [CW-1:0]    a_idx;
    logic [3:0]       a_nib;
    logic [3:0]       b_nib;
    logic [3:0]       slice_res;
    logic             slice_chain;
    logic             z_next;
    logic             h_next;
    logic [7:0]       flags_next;

    assign idx   = msb_first(op_q) ? (LAST - cnt) : cnt;
    assign a_idx = (op_q == OP_SWAP) ? (idx ^ CW'(1)) : idx;
    assign a_nib = a_q[{a_idx, 2'b00} +: 4];
    assign b_nib = b_q[{idx, 2'b00} +: 4];

    // One register carries both the arithmetic carry and the shift bit between nibbles.
    alu4_slice u_slice (
        .a         (a_nib),
        .b         (b_nib),
        .op        (op_q),
        .chain_in  (link),
        .shift_in  (link),
        .res       (slice_res),
        .chain_out (slice_chain)
    );

    assign z_next = z_acc & (slice_res == 4'h0);
    assign h_next = (int'(cnt) == HC_NIBBLE) ? slice_chain : h_acc;

    always_comb begin
        flags_next         = 8'h00;
        flags_next[FLAG_Z] = z_next;
        flags_next[FLAG_N] = is_sub(op_q);
        flags_next[FLAG_H] = is_arith(op_q) ? h_next : (op_q == OP_AND);
        flags_next[FLAG_C] = slice_chain;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state   <= ST_IDLE;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            res_q   <= '0;
            flags_q <= 8'h00;
            op_q    <= OP_ADD;
            a_q     <= '0;
            b_q     <= '0;
            cnt     <= '0;
            link    <= 1'b0;
            z_acc   <= 1'b1;
            h_acc   <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state)
                ST_IDLE, ST_DONE: begin
                    if (bus.start_i) begin
                        op_q   <= bus.op_i;
                        a_q    <= bus.a_i;
                        b_q    <= bus.b_i;
                        link   <= chain_seed(bus.op_i, bus.carry_i, bus.a_i[WIDTH-1], bus.a_i[0]);
                        cnt    <= '0;
                        z_acc  <= 1'b1;
                        h_acc  <= 1'b0;
                        busy_q <= 1'b1;
                        state  <= ST_RUN;
                    end else begin
                        state  <= ST_IDLE;
                    end
                end
                ST_RUN: begin
                    // CP keeps A as its result; only the flags see the difference.
                    res_q[{idx, 2'b00} +: 4] <= (op_q == OP_CP) ? a_nib : slice_res;
                    link  <= slice_chain;
                    z_acc <= z_next;
                    h_acc <= h_next;
                    cnt   <= cnt + CW'(1);
                    if (cnt == LAST) begin
                        flags_q <= flags_next;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        state   <= ST_DONE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign bus.busy_o  = busy_q;
    assign bus.done_o  = done_q;
    assign bus.res_o   = res_q;
    assign bus.flags_o = flags_q;
endmodule

// File: tb/tb_alu_nibble_serial.sv
// Directed scoreboard bench for alu_nibble_serial: an 8-bit instance and a 16-bit
// instance (H from nibble 2) share clock and reset.
module tb_alu_nibble_serial;
    import alu_pkg::*;

    typedef struct {
        logic [15:0] res;
        logic [7:0]  flags;
        int          lat;
    } exp_t;

    logic clk;
    logic rst_n;
    exp_t sb[$];
    int   tests_run    = 0;
    int   tests_failed = 0;

    alu_nibble_serial_if #(.WIDTH(8))  bus8 ();
    alu_nibble_serial_if #(.WIDTH(16)) bus16 ();

    alu_nibble_serial #(.WIDTH(8), .HC_NIBBLE(0)) dut8 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus8)
    );

    alu_nibble_serial #(.WIDTH(16), .HC_NIBBLE(2)) dut16 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus16)
    );

    always #5 clk = ~clk;

    task automatic expect_eq(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        tests_run++;
        assert (obs === exp) else begin
            tests_failed++;
            $error("[TB] FAIL %s: got %h, wanted %h", tag, obs, exp);
        end
    endtask

    function automatic logic get_busy(input bit wide);
        return wide ? bus16.busy_o : bus8.busy_o;
    endfunction

    function automatic logic get_done(input bit wide);
        return wide ? bus16.done_o : bus8.done_o;
    endfunction

    task automatic drive(input bit wide, input logic start, input logic [3:0] op,
                         input logic [15:0] a, input logic [15:0] b, input logic cin);
        if (wide) begin
            bus16.start_i = start;
            bus16.op_i    = op;
            bus16.a_i     = a;
            bus16.b_i     = b;
            bus16.carry_i = cin;
            bus8.start_i  = 1'b0;
        end else begin
            bus8.start_i  = start;
            bus8.op_i     = op;
            bus8.a_i      = a[7:0];
            bus8.b_i      = b[7:0];
            bus8.carry_i  = cin;
            bus16.start_i = 1'b0;
        end
    endtask

    // Pushes the expected result, then pulses start across exactly one sampling edge.
    task automatic apply_stimulus(input bit wide, input logic [3:0] op, input logic [15:0] a,
                                  input logic [15:0] b, input logic cin,
                                  input logic [15:0] exp_res, input logic [7:0] exp_flags);
        sb.push_back('{res: exp_res, flags: exp_flags, lat: (wide ? 5 : 3)});
        drive(wide, 1'b1, op, a, b, cin);
        @(posedge clk);
        #1;
        drive(wide, 1'b0, op, a, b, cin);
    endtask

    // Entered first_cycle cycles after the start edge; waits for done_o and scores it.
    task automatic check_output(input bit wide, input string tag, input int first_cycle);
        int   cycles;
        int   busy_cnt;
        exp_t e;
        cycles   = first_cycle;
        busy_cnt = first_cycle - 1;
        if (get_busy(wide)) busy_cnt++;
        while (!get_done(wide) && cycles < 20) begin
            @(posedge clk);
            #1;
            cycles++;
            if (get_busy(wide)) busy_cnt++;
        end
        expect_eq({tag, " done seen"}, 16'(get_done(wide)), 16'd1);
        if (sb.size() == 0) begin
            expect_eq({tag, " scoreboard entry"}, 16'd0, 16'd1);
            return;
        end
        e = sb.pop_front();
        expect_eq({tag, " latency"}, 16'(cycles), 16'(e.lat));
        expect_eq({tag, " busy cycles"}, 16'(busy_cnt), 16'(e.lat - 1));
        expect_eq({tag, " res"}, wide ? bus16.res_o : {8'h00, bus8.res_o}, e.res);
        expect_eq({tag, " flags"}, {8'h00, wide ? bus16.flags_o : bus8.flags_o}, {8'h00, e.flags});
    endtask

    task automatic idle_check(input bit wide, input string tag);
        @(posedge clk);
        #1;
        expect_eq({tag, " done pulse ends"}, 16'(get_done(wide)), 16'd0);
        expect_eq({tag, " busy idle"}, 16'(get_busy(wide)), 16'd0);
    endtask

    initial begin
        logic done_seen;
        clk   = 1'b0;
        rst_n = 1'b0;
        drive(1'b1, 1'b0, OP_ADD, 16'h0000, 16'h0000, 1'b0);
        drive(1'b0, 1'b0, OP_ADD, 16'h0000, 16'h0000, 1'b0);
        repeat (3) @(posedge clk);
        #1;
        expect_eq("reset busy8",   16'(bus8.busy_o), 16'd0);
        expect_eq("reset done8",   16'(bus8.done_o), 16'd0);
        expect_eq("reset res8",    {8'h00, bus8.res_o}, 16'h0000);
        expect_eq("reset flags8",  {8'h00, bus8.flags_o}, 16'h0000);
        expect_eq("reset busy16",  16'(bus16.busy_o), 16'd0);
        expect_eq("reset res16",   bus16.res_o, 16'h0000);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        apply_stimulus(0, OP_ADD,  16'h3A, 16'hC6, 0, 16'h00, 8'hB0); check_output(0, "add",   1); idle_check(0, "add");
        apply_stimulus(0, OP_SBC,  16'h10, 16'h01, 1, 16'h0E, 8'h60); check_output(0, "sbc",   1); idle_check(0, "sbc");
        apply_stimulus(0, OP_CP,   16'h42, 16'h42, 0, 16'h42, 8'hC0); check_output(0, "cp eq", 1); idle_check(0, "cp eq");
        apply_stimulus(0, OP_AND,  16'h0F, 16'hF0, 0, 16'h00, 8'hA0); check_output(0, "and",   1); idle_check(0, "and");
        apply_stimulus(0, OP_XOR,  16'hFF, 16'hFF, 0, 16'h00, 8'h80); check_output(0, "xor",   1); idle_check(0, "xor");
        apply_stimulus(0, OP_RR,   16'h01, 16'h00, 1, 16'h80, 8'h10); check_output(0, "rr",    1); idle_check(0, "rr");
        apply_stimulus(0, OP_SRA,  16'h81, 16'h00, 0, 16'hC0, 8'h10); check_output(0, "sra",   1); idle_check(0, "sra");
        apply_stimulus(0, OP_RLC,  16'h80, 16'h00, 0, 16'h01, 8'h10); check_output(0, "rlc",   1); idle_check(0, "rlc");
        apply_stimulus(0, OP_SWAP, 16'hF0, 16'h00, 0, 16'h0F, 8'h00); check_output(0, "swap",  1); idle_check(0, "swap");
        apply_stimulus(0, OP_ADC,  16'h0F, 16'h00, 1, 16'h10, 8'h20); check_output(0, "adc",   1); idle_check(0, "adc");
        apply_stimulus(0, OP_SUB,  16'h05, 16'h07, 0, 16'hFE, 8'h70); check_output(0, "sub",   1); idle_check(0, "sub");
        apply_stimulus(0, OP_CP,   16'h10, 16'h20, 0, 16'h10, 8'h50); check_output(0, "cp lt", 1); idle_check(0, "cp lt");
        apply_stimulus(0, OP_ADD,  16'h01, 16'h01, 1, 16'h02, 8'h00); check_output(0, "add ci", 1); idle_check(0, "add ci");
        apply_stimulus(0, OP_OR,   16'h50, 16'h0A, 0, 16'h5A, 8'h00); check_output(0, "or",    1); idle_check(0, "or");
        apply_stimulus(0, OP_RL,   16'h80, 16'h00, 0, 16'h00, 8'h90); check_output(0, "rl",    1); idle_check(0, "rl");
        apply_stimulus(0, OP_SLA,  16'h41, 16'h00, 1, 16'h82, 8'h00); check_output(0, "sla",   1); idle_check(0, "sla");
        apply_stimulus(0, OP_SRL,  16'h03, 16'h00, 1, 16'h01, 8'h10); check_output(0, "srl",   1); idle_check(0, "srl");
        apply_stimulus(0, OP_RRC,  16'h01, 16'h00, 0, 16'h80, 8'h10); check_output(0, "rrc",   1); idle_check(0, "rrc");
        apply_stimulus(0, OP_SRA,  16'h40, 16'h00, 0, 16'h20, 8'h00); check_output(0, "sra pos", 1); idle_check(0, "sra pos");

        apply_stimulus(1, OP_ADD,  16'h0FFF, 16'h0001, 0, 16'h1000, 8'h20); check_output(1, "add16",  1); idle_check(1, "add16");
        apply_stimulus(1, OP_SRA,  16'h8001, 16'h0000, 0, 16'hC000, 8'h10); check_output(1, "sra16",  1); idle_check(1, "sra16");
        apply_stimulus(1, OP_SWAP, 16'h1234, 16'h0000, 0, 16'h2143, 8'h00); check_output(1, "swap16", 1); idle_check(1, "swap16");

        // Restart issued in the DONE cycle of the previous op.
        apply_stimulus(0, OP_ADD, 16'h01, 16'h02, 0, 16'h03, 8'h00); check_output(0, "b2b first", 1);
        apply_stimulus(0, OP_XOR, 16'h0F, 16'h0F, 0, 16'h00, 8'h80); check_output(0, "b2b second", 1);
        idle_check(0, "b2b");

        // start_i stays high into RUN with a changed operand; it must be ignored.
        sb.push_back('{res: 16'h0033, flags: 8'h00, lat: 3});
        drive(0, 1'b1, OP_ADD, 16'h11, 16'h22, 0);
        @(posedge clk);
        #1;
        expect_eq("held busy", 16'(bus8.busy_o), 16'd1);
        drive(0, 1'b1, OP_ADD, 16'h55, 16'h22, 0);
        @(posedge clk);
        #1;
        drive(0, 1'b0, OP_ADD, 16'h55, 16'h22, 0);
        check_output(0, "held", 2);
        idle_check(0, "held");

        // Reset part way through an op.
        drive(0, 1'b1, OP_ADD, 16'h12, 16'h34, 0);
        @(posedge clk);
        #1;
        drive(0, 1'b0, OP_ADD, 16'h12, 16'h34, 0);
        @(posedge clk);
        #1;
        expect_eq("midrun busy", 16'(bus8.busy_o), 16'd1);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        expect_eq("midrun rst busy",  16'(bus8.busy_o), 16'd0);
        expect_eq("midrun rst res",   {8'h00, bus8.res_o}, 16'h0000);
        expect_eq("midrun rst flags", {8'h00, bus8.flags_o}, 16'h0000);
        expect_eq("midrun rst res16", bus16.res_o, 16'h0000);
        rst_n = 1'b1;
        done_seen = 1'b0;
        repeat (5) begin
            @(posedge clk);
            #1;
            if (bus8.done_o) done_seen = 1'b1;
        end
        expect_eq("midrun no done", 16'(done_seen), 16'd0);
        expect_eq("scoreboard drained", 16'(sb.size()), 16'd0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule
